// File: rtl/multicycle_seq_if.sv
// Instruction and data memory request/acknowledge handshakes for multicycle_seq.
// The sequencer drives requests (master); the memories return acks (slave).
interface multicycle_seq_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a simplified RV32 datapath.
// Drives datapath strobes, waits on stalling memories, counts retirements, halts on errors.
module multicycle_seq #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_seq_if.master     mem_if,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  input  logic                 ops_equal_i,
  input  logic                 op1_lt_op2_i,
  output logic                 ir_wen_o,
  output logic                 pc_wen_o,
  output logic                 pc_src_o,
  output logic [3:0]           alu_sel_o,
  output logic                 alu_src_o,
  output logic                 reg_wen_o,
  output logic                 reg_wdata_src_o,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic [1:0]           err_code_o,
  output logic [CNT_W-1:0]     instr_cnt_o
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrIllegal = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
  typedef enum logic [1:0] {ClsOp, ClsLoad, ClsStore, ClsBranch} cls_e;

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [1:0]        br_q, br_d;        // {use lt, invert}
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic              alu_src_q, alu_src_d;
  logic              wdsrc_q, wdsrc_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;

  logic timeout;
  logic taken;
  logic unused_funct7;

  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

  assign timeout = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT - 1));
  assign taken   = br_q[1] ? (op1_lt_op2_i ^ br_q[0]) : (ops_equal_i ^ br_q[0]);

  // funct7[5] selects SUB only for register-register ops, SRA for both shift forms.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
    logic [3:0] sel;
    sel = AluAdd;
    case (f3)
      3'b000:  sel = (alt && is_reg) ? AluSub : AluAdd;
      3'b001:  sel = AluSll;
      3'b010:  sel = AluSlt;
      3'b011:  sel = AluSltu;
      3'b100:  sel = AluXor;
      3'b101:  sel = alt ? AluSra : AluSrl;
      3'b110:  sel = AluOr;
      default: sel = AluAnd;
    endcase
    return sel;
  endfunction

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    br_d      = br_q;
    alu_sel_d = alu_sel_q;
    alu_src_d = alu_src_q;
    wdsrc_d   = wdsrc_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    wait_d    = '0;

    mem_if.imem_req = 1'b0;
    mem_if.dmem_req = 1'b0;
    mem_if.dmem_we  = 1'b0;
    ir_wen_o        = 1'b0;
    pc_wen_o        = 1'b0;
    pc_src_o        = 1'b0;
    reg_wen_o       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        mem_if.imem_req = 1'b1;
        if (mem_if.imem_ack) begin
          ir_wen_o = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          err_d   = ErrTimeout;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        state_d = StExec;
        case (opcode_i)
          OpcOp, OpcOpImm: begin
            cls_d     = ClsOp;
            alu_sel_d = alu_decode(funct3_i, funct7_i[5], opcode_i == OpcOp);
            alu_src_d = (opcode_i == OpcOpImm);
            wdsrc_d   = 1'b0;
          end
          OpcLoad, OpcStore: begin
            cls_d     = (opcode_i == OpcLoad) ? ClsLoad : ClsStore;
            alu_sel_d = AluAdd;
            alu_src_d = 1'b1;
            wdsrc_d   = (opcode_i == OpcLoad);
          end
          OpcBranch: begin
            cls_d     = ClsBranch;
            br_d      = {funct3_i[2], funct3_i[0]};
            alu_sel_d = AluSub;
            alu_src_d = 1'b0;
            wdsrc_d   = 1'b0;
            if (funct3_i[1]) begin
              err_d   = ErrIllegal;
              state_d = StHalt;
            end
          end
          default: begin
            err_d   = ErrIllegal;
            state_d = StHalt;
          end
        endcase
      end
      StExec: begin
        case (cls_q)
          ClsOp:            state_d = StWb;
          ClsLoad, ClsStore: state_d = StMem;
          default: begin
            pc_wen_o = 1'b1;
            pc_src_o = taken;
            cnt_d    = cnt_q + 1'b1;
            state_d  = stop_i ? StIdle : StFetch;
          end
        endcase
      end
      StMem: begin
        mem_if.dmem_req = 1'b1;
        mem_if.dmem_we  = (cls_q == ClsStore);
        if (mem_if.dmem_ack) begin
          if (cls_q == ClsStore) begin
            pc_wen_o = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            state_d  = stop_i ? StIdle : StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          err_d   = ErrTimeout;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        reg_wen_o = 1'b1;
        pc_wen_o  = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        state_d   = stop_i ? StIdle : StFetch;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cls_q     <= ClsOp;
      br_q      <= '0;
      alu_sel_q <= '0;
      alu_src_q <= 1'b0;
      wdsrc_q   <= 1'b0;
      err_q     <= ErrNone;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      br_q      <= br_d;
      alu_sel_q <= alu_sel_d;
      alu_src_q <= alu_src_d;
      wdsrc_q   <= wdsrc_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  assign alu_sel_o       = alu_sel_q;
  assign alu_src_o       = alu_src_q;
  assign reg_wdata_src_o = wdsrc_q;
  assign err_code_o      = err_q;
  assign instr_cnt_o     = cnt_q;
  assign busy_o          = (state_q != StIdle) && (state_q != StHalt);
  assign halted_o        = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: directed and random instructions checked
// against a per-instruction cycle schedule derived from class, stalls and flags.
module tb_multicycle_seq;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stop_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [2:0]  funct3_i;
  logic        ops_equal_i, op1_lt_op2_i;
  logic        ir_wen_o, pc_wen_o, pc_src_o, alu_src_o, reg_wen_o, reg_wdata_src_o;
  logic        busy_o, halted_o;
  logic [3:0]  alu_sel_o;
  logic [1:0]  err_code_o;
  logic [31:0] instr_cnt_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] cnt_exp = '0;

  multicycle_seq_if bus ();

  multicycle_seq #(.TIMEOUT(15), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_if          (bus),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .opcode_i        (opcode_i),
    .funct3_i        (funct3_i),
    .funct7_i        (funct7_i),
    .ops_equal_i     (ops_equal_i),
    .op1_lt_op2_i    (op1_lt_op2_i),
    .ir_wen_o        (ir_wen_o),
    .pc_wen_o        (pc_wen_o),
    .pc_src_o        (pc_src_o),
    .alu_sel_o       (alu_sel_o),
    .alu_src_o       (alu_src_o),
    .reg_wen_o       (reg_wen_o),
    .reg_wdata_src_o (reg_wdata_src_o),
    .busy_o          (busy_o),
    .halted_o        (halted_o),
    .err_code_o      (err_code_o),
    .instr_cnt_o     (instr_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ALU selection expected from the instruction fields (add=0 sub=1 sll slt sltu xor srl sra or and)
  function automatic logic [3:0] exp_alu(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] tbl [8];
    logic [3:0] r;
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (opc == LD || opc == ST) return 4'd0;
    if (opc == BR) return 4'd1;
    r = tbl[f3];
    if (f7[5] && f3 == 3'd5) r = 4'd7;
    if (f7[5] && f3 == 3'd0 && opc == OP) r = 4'd1;
    return r;
  endfunction

  function automatic logic exp_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0:    return eq;
      3'd1:    return !eq;
      3'd4:    return lt;
      default: return !lt;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_halted", halted_o, 1'b0);
    chk1("rst_imem_req", bus.imem_req, 1'b0);
    chk1("rst_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_err", 32'(err_code_o), 32'd0);
    chk("rst_cnt", instr_cnt_o, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel_o), 32'd0);
    tick();
    rst = 1'b0;
    cnt_exp = '0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    #1;
    chk1("idle_busy", busy_o, 1'b0);
    tick();
    start_i = 1'b0;
  endtask

  // Entered with the DUT in FETCH; leaves it in FETCH after retiring (restarting if stopped).
  task automatic do_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic eq, input logic lt, input int fw, input int dw,
                          input logic stp);
    logic is_ld, is_st, is_br;
    is_ld = (opc == LD);
    is_st = (opc == ST);
    is_br = (opc == BR);
    opcode_i = opc; funct3_i = f3; funct7_i = f7;
    ops_equal_i = eq; op1_lt_op2_i = lt; stop_i = 1'b0;
    for (int k = 0; k <= fw; k++) begin
      bus.imem_ack = (k == fw);
      bus.dmem_ack = 1'($urandom);
      #1;
      chk1("fetch_req", bus.imem_req, 1'b1);
      chk1("fetch_ir_wen", ir_wen_o, k == fw);
      chk1("fetch_pc_wen", pc_wen_o, 1'b0);
      tick();
    end
    bus.imem_ack = 1'($urandom);
    bus.dmem_ack = 1'($urandom);
    #1;
    chk1("decode_quiet", |{bus.imem_req, bus.dmem_req, ir_wen_o, pc_wen_o, reg_wen_o}, 1'b0);
    tick();
    stop_i = is_br ? stp : 1'b0;
    #1;
    chk("exec_alu_sel", 32'(alu_sel_o), 32'(exp_alu(opc, f3, f7)));
    chk1("exec_alu_src", alu_src_o, !(opc == OP || is_br));
    chk1("exec_wdsrc", reg_wdata_src_o, is_ld);
    chk1("exec_reqs", |{bus.imem_req, bus.dmem_req, reg_wen_o}, 1'b0);
    chk1("exec_pc_wen", pc_wen_o, is_br);
    if (is_br) chk1("branch_pc_src", pc_src_o, exp_taken(f3, eq, lt));
    tick();
    if (is_ld || is_st) begin
      for (int j = 0; j <= dw; j++) begin
        bus.dmem_ack = (j == dw);
        bus.imem_ack = 1'($urandom);
        stop_i = (is_st && j == dw) ? stp : 1'b0;
        #1;
        chk1("mem_req", bus.dmem_req, 1'b1);
        chk1("mem_we", bus.dmem_we, is_st);
        chk1("mem_imem_req", bus.imem_req, 1'b0);
        chk1("mem_reg_wen", reg_wen_o, 1'b0);
        chk1("mem_pc_wen", pc_wen_o, is_st && j == dw);
        tick();
      end
    end
    if (!is_br && !is_st) begin
      stop_i = stp;
      #1;
      chk1("wb_reg_wen", reg_wen_o, 1'b1);
      chk1("wb_pc_wen", pc_wen_o, 1'b1);
      chk1("wb_pc_src", pc_src_o, 1'b0);
      chk1("wb_wdsrc", reg_wdata_src_o, is_ld);
      tick();
    end
    stop_i = 1'b0;
    cnt_exp = cnt_exp + 1;
    #1;
    chk("instr_cnt", instr_cnt_o, cnt_exp);
    chk1("post_retire_fetch", bus.imem_req, !stp);
    chk1("post_retire_busy", busy_o, !stp);
    if (stp) do_start();
  endtask

  initial begin
    logic [6:0] opcs [5];
    logic [2:0] brf3 [4];
    logic [6:0] opc;
    logic [2:0] f3;
    opcs = '{OP, OPI, LD, ST, BR};
    brf3 = '{3'd0, 3'd1, 3'd4, 3'd5};
    start_i = 0; stop_i = 0; opcode_i = '0; funct3_i = '0; funct7_i = '0;
    ops_equal_i = 0; op1_lt_op2_i = 0; bus.imem_ack = 0; bus.dmem_ack = 0;
    rst = 1'b1;
    tick();
    do_reset();
    do_start();

    // directed: ADD, BEQ taken/not, BLT taken, LOAD with 3 waits, STORE, SUB/SRAI, stop
    do_instr(OP,  3'd0, 7'h00, 0, 0, 0, 0, 0);
    do_instr(BR,  3'd0, 7'h00, 1, 0, 0, 0, 0);
    do_instr(BR,  3'd0, 7'h00, 0, 0, 0, 0, 0);
    do_instr(BR,  3'd4, 7'h00, 0, 1, 0, 0, 0);
    do_instr(LD,  3'd2, 7'h00, 0, 0, 0, 3, 0);
    do_instr(ST,  3'd2, 7'h00, 0, 0, 1, 0, 0);
    do_instr(OP,  3'd0, 7'h20, 0, 0, 2, 0, 0);
    do_instr(OPI, 3'd5, 7'h20, 0, 0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      opc = opcs[$urandom_range(0, 4)];
      f3  = (opc == BR) ? brf3[$urandom_range(0, 3)] : 3'($urandom);
      do_instr(opc, f3, 7'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    // reset mid-MEM drops the request at once and clears the count
    opcode_i = LD; funct3_i = 3'd2; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
    tick(); tick();
    bus.imem_ack = 1'b0;
    tick();
    #1;
    chk1("pre_rst_dmem_req", bus.dmem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("rst_mid_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_mid_cnt", instr_cnt_o, 32'd0);
    chk1("rst_mid_busy", busy_o, 1'b0);
    tick();
    rst = 1'b0;
    cnt_exp = '0;
    do_start();
    do_instr(OP, 3'd7, 7'h00, 0, 0, 0, 0, 0);

    // illegal opcode, then illegal branch funct3: halt with err 01, start ignored
    for (int t = 0; t < 2; t++) begin
      opcode_i = (t == 0) ? 7'h7F : BR;
      funct3_i = (t == 0) ? 3'd0 : 3'd2;
      bus.imem_ack = 1'b1;
      tick(); tick();
      start_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
        #1;
        chk1("illegal_halted", halted_o, 1'b1);
        chk("illegal_err", 32'(err_code_o), 32'd1);
        chk1("illegal_no_req", bus.imem_req | bus.dmem_req, 1'b0);
        tick();
      end
      start_i = 1'b0;
      do_reset();
      do_start();
    end

    // fetch timeout: imem_req high exactly 15 cycles
    bus.imem_ack = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #1;
      chk1("tmo_imem_req", bus.imem_req, 1'b1);
      tick();
    end
    #1;
    chk1("tmo_halted", halted_o, 1'b1);
    chk("tmo_err", 32'(err_code_o), 32'd2);
    chk1("tmo_req_off", bus.imem_req, 1'b0);
    do_reset();
    do_start();

    // data timeout on a load
    opcode_i = LD; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
    tick(); tick();
    bus.imem_ack = 1'b0;
    tick();
    for (int c = 0; c < 15; c++) begin
      #1;
      chk1("dtmo_dmem_req", bus.dmem_req, 1'b1);
      tick();
    end
    #1;
    chk1("dtmo_halted", halted_o, 1'b1);
    chk("dtmo_err", 32'(err_code_o), 32'd2);
    chk1("dtmo_req_off", bus.dmem_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
